// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg: states and constants shared by the RMII transmit framer and its CRC
package mac_tx_pkg;
    typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, IFG} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam int FCS_DIBITS = 16;
endpackage

// File: rtl/mac_crc32_d2.sv
// mac_crc32_d2: reflected CRC-32 advanced by one dibit (bit 0 first) per enabled cycle
module mac_crc32_d2
    import mac_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);
    logic [31:0] c1, c2;
    always_comb begin
        c1 = (crc >> 1) ^ ((crc[0] ^ d[0]) ? CRC_POLY_REFL : 32'h0);
        c2 = (c1 >> 1) ^ ((c1[0] ^ d[1]) ? CRC_POLY_REFL : 32'h0);
    end
    always_ff @(posedge clk) begin
        if (rst || clr) crc <= CRC_INIT;
        else if (en) crc <= c2;
    end
endmodule

// File: rtl/mac_tx_rmii_framer.sv
// mac_tx_rmii_framer: byte stream to RMII dibits with preamble/SFD and IFG; FCS appended when MAC_TX_FCS_EN is defined
module mac_tx_rmii_framer
    import mac_tx_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_DIBITS = 48
) (
    input  logic       Iclk,
    input  logic       Irst,
    input  logic [7:0] Itx_data,
    input  logic       Itx_valid,
    input  logic       Itx_last,
    output logic       Otx_ready,
    output logic [1:0] Otxd,
    output logic       Otx_en,
    output logic       Obusy,
    output logic       Ounderrun
);
`ifdef MAC_TX_FCS_EN
    localparam int SW = 32;
    localparam state_t DONE = FCS;
    logic [31:0] crc;
`else
    localparam int SW = 8;
    localparam state_t DONE = IFG;
`endif
    localparam logic [15:0] PRE_END = 16'(4 * (PREAMBLE_BYTES + 1) - 1);
    localparam logic [15:0] FCS_END = 16'(FCS_DIBITS - 1);
    localparam logic [15:0] IFG_END = 16'(IFG_DIBITS - 1);
    state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [SW-1:0] sh, word, fcs_word;
    logic last, load, en_n;
    assign Otx_ready = (state == PRE && cnt == PRE_END) || (state == DATA && cnt[1:0] == 2'd3 && !last);
`ifdef MAC_TX_FCS_EN
    mac_crc32_d2 u_crc (
        .clk(Iclk),
        .rst(Irst),
        .clr(state == IDLE),
        .en (state_n == DATA),
        .d  (word[1:0]),
        .crc(crc)
    );
    assign fcs_word = ~crc;
`else
    assign fcs_word = '0;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = Itx_valid ? PRE : IDLE;
            PRE:     state_n = cnt != PRE_END ? PRE : Itx_valid ? DATA : IFG;
            DATA:    state_n = cnt[1:0] != 2'd3 ? DATA : last ? DONE : Itx_valid ? DATA : IFG;
            FCS:     state_n = cnt == FCS_END ? IFG : FCS;
            IFG:     state_n = cnt == IFG_END ? IDLE : IFG;
            default: state_n = IDLE;
        endcase
        cnt_n = state_n != state ? 16'd0 : cnt + 16'd1;
        // a fresh byte (or the whole FCS word) enters the shifter on phase entry and byte boundaries
        load = state_n != state || (cnt_n[1:0] == 2'd0 && state_n != FCS);
        word = !load ? sh
             : state_n == PRE ? SW'(cnt_n[15:2] < 14'(PREAMBLE_BYTES) ? PREAMBLE_BYTE : SFD_BYTE)
             : state_n == DATA ? SW'(Itx_data)
             : state_n == FCS ? fcs_word
             : '0;
        en_n = state_n == PRE || state_n == DATA || state_n == FCS;
    end
    always_ff @(posedge Iclk) begin
        if (Irst) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            last <= 1'b0;
            Otxd <= 2'b00;
            Otx_en <= 1'b0;
            Obusy <= 1'b0;
            Ounderrun <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sh <= word >> 2;
            if (state_n == DATA && load) last <= Itx_last;
            Otx_en <= en_n;
            Otxd <= en_n ? word[1:0] : 2'b00;
            Obusy <= state_n != IDLE;
            Ounderrun <= Otx_ready && !Itx_valid;
        end
    end
endmodule

// File: tb/tb_mac_tx_rmii_framer.sv
// tb_mac_tx_rmii_framer: randomized frames checked cycle by cycle against a wire-level model
module tb_mac_tx_rmii_framer;
    localparam int P = 7;
    localparam int IFG = 48;
`ifdef MAC_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif
    logic Iclk = 1'b0;
    logic Irst = 1'b1;
    logic Itx_valid = 1'b0;
    logic Itx_last = 1'b0;
    logic [7:0] Itx_data = 8'h00;
    logic Otx_ready, Otx_en, Obusy, Ounderrun;
    logic [1:0] Otxd;
    int checks = 0;
    int errors = 0;
    logic [8:0] bq[$];
    logic [8:0] nq[$];
    logic [5:0] tr[$];
    logic [5:0] ex[$];

    always #5 Iclk = ~Iclk;

    mac_tx_rmii_framer #(.PREAMBLE_BYTES(P), .IFG_DIBITS(IFG)) dut (
        .Iclk(Iclk),
        .Irst(Irst),
        .Itx_data(Itx_data),
        .Itx_valid(Itx_valid),
        .Itx_last(Itx_last),
        .Otx_ready(Otx_ready),
        .Otxd(Otxd),
        .Otx_en(Otx_en),
        .Obusy(Obusy),
        .Ounderrun(Ounderrun)
    );

    function automatic logic [31:0] crc32(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c ^= {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    // expected {busy,en,ready,underrun,txd} per cycle: idle cycle, wire bytes, then the gap
    task automatic model(input logic [7:0] d[$], input bit complete);
        logic [7:0] w[$];
        logic [31:0] c;
        logic rdy, ur;
        int n;
        n = d.size();
        ex.push_back(6'b0);
        for (int i = 0; i < P; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (d[i]) w.push_back(d[i]);
        if (FCS_ON && complete) begin
            c = crc32(d);
            for (int i = 0; i < 4; i++) w.push_back(c[8*i +: 8]);
        end
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                rdy = k == 3 && i >= P && (i < P + n || (!complete && i == P + n));
                ex.push_back({1'b1, 1'b1, rdy, 1'b0, w[i][2*k +: 2]});
            end
        end
        for (int i = 0; i < IFG; i++) begin
            ur = !complete && i == 0;
            ex.push_back({1'b1, 1'b0, 1'b0, ur, 2'b00});
        end
    endtask

    task automatic push_frame(input logic [7:0] d[$], input bit complete);
        foreach (d[i]) bq.push_back({complete && i == d.size() - 1, d[i]});
    endtask

    task automatic set_inputs();
        if (bq.size() > 0) begin
            Itx_valid = 1'b1;
            Itx_data = bq[0][7:0];
            Itx_last = bq[0][8];
        end else begin
            Itx_valid = 1'b0;
            Itx_data = 8'h00;
            Itx_last = 1'b0;
        end
    endtask

    // runs ncyc cycles as the upstream FIFO; at rst_cyc pulses reset and swaps in nq
    task automatic run(input int ncyc, input int rst_cyc);
        logic hs;
        tr.delete();
        set_inputs();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Iclk);
            tr.push_back({Obusy, Otx_en, Otx_ready, Ounderrun, Otxd});
            hs = Otx_ready && Itx_valid && !Irst;
            @(posedge Iclk);
            #1;
            if (hs) void'(bq.pop_front());
            Irst = (c + 1 == rst_cyc);
            if (c + 1 == rst_cyc) bq = nq;
            set_inputs();
        end
    endtask

    task automatic rand_frame(output logic [7:0] d[$], input int n);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        Irst = 1'b1;
        bq.delete();
        set_inputs();
        repeat (3) @(posedge Iclk);
        #1;
        Irst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Iclk);
            checks++;
            if ({Obusy, Otx_en, Otx_ready, Ounderrun, Otxd} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b expected 000000", i, {Obusy, Otx_en, Otx_ready, Ounderrun, Otxd});
            end
        end
        @(posedge Iclk);
        #1;
    endtask

    task automatic test_single_byte();
        logic [7:0] d[$];
        logic [1:0] lit[8];
        int en_cnt;
        lit = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
        d = '{8'hA5};
        ex.delete();
        model(d, 1'b1);
        push_frame(d, 1'b1);
        run(ex.size(), -1);
        foreach (ex[i]) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL single_byte cycle %0d: got %b expected %b", i, tr[i], ex[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tr[29+i][1:0] !== lit[i]) begin
                errors++;
                $display("FAIL single_byte_dibit cycle %0d: got %b expected %b", 29 + i, tr[29+i][1:0], lit[i]);
            end
        end
        en_cnt = 0;
        foreach (tr[i]) en_cnt += int'(tr[i][4]);
        checks++;
        if (en_cnt != 4 * (8 + 1) + (FCS_ON ? 16 : 0)) begin
            errors++;
            $display("FAIL single_byte_len: got %0d expected %0d", en_cnt, 4 * (8 + 1) + (FCS_ON ? 16 : 0));
        end
    endtask

    task automatic test_crc_vector();
        logic [7:0] d[$];
        int en_cnt;
`ifdef MAC_TX_FCS_EN
        logic [7:0] got;
        logic [7:0] fcs[4];
        int base;
        fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
`endif
        for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
        ex.delete();
        model(d, 1'b1);
        push_frame(d, 1'b1);
        run(ex.size(), -1);
        foreach (ex[i]) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL crc_vector cycle %0d: got %b expected %b", i, tr[i], ex[i]);
            end
        end
        en_cnt = 0;
        foreach (tr[i]) en_cnt += int'(tr[i][4]);
        checks++;
        if (en_cnt != 4 * (8 + 9) + (FCS_ON ? 16 : 0)) begin
            errors++;
            $display("FAIL crc_vector_len: got %0d expected %0d", en_cnt, 4 * (8 + 9) + (FCS_ON ? 16 : 0));
        end
`ifdef MAC_TX_FCS_EN
        base = 1 + 4 * (P + 1 + 9);
        for (int j = 0; j < 4; j++) begin
            got = {tr[base+4*j+3][1:0], tr[base+4*j+2][1:0], tr[base+4*j+1][1:0], tr[base+4*j][1:0]};
            checks++;
            if (got !== fcs[j]) begin
                errors++;
                $display("FAIL crc_vector_fcs byte %0d: got %h expected %h", j, got, fcs[j]);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] d[$];
        for (int f = 0; f < 6; f++) begin
            rand_frame(d, $urandom_range(1, 12));
            ex.delete();
            model(d, 1'b1);
            push_frame(d, 1'b1);
            run(ex.size(), -1);
            foreach (ex[i]) begin
                checks++;
                if (tr[i] !== ex[i]) begin
                    errors++;
                    $display("FAIL random frame %0d cycle %0d: got %b expected %b", f, i, tr[i], ex[i]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] d[$];
        int ur_cnt;
        rand_frame(d, 2);
        ex.delete();
        model(d, 1'b0);
        push_frame(d, 1'b0);
        run(ex.size(), -1);
        foreach (ex[i]) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL underrun cycle %0d: got %b expected %b", i, tr[i], ex[i]);
            end
        end
        ur_cnt = 0;
        foreach (tr[i]) ur_cnt += int'(tr[i][2]);
        checks++;
        if (ur_cnt != 1) begin
            errors++;
            $display("FAIL underrun_pulses: got %0d expected 1", ur_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[$];
        logic [7:0] b[$];
        int f, r;
        rand_frame(a, $urandom_range(1, 8));
        rand_frame(b, $urandom_range(1, 8));
        ex.delete();
        model(a, 1'b1);
        model(b, 1'b1);
        push_frame(a, 1'b1);
        push_frame(b, 1'b1);
        run(ex.size(), -1);
        foreach (ex[i]) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i, tr[i], ex[i]);
            end
        end
        f = -1;
        r = -1;
        for (int i = 1; i < tr.size(); i++) begin
            if (f < 0 && tr[i-1][4] && !tr[i][4]) f = i;
            else if (f >= 0 && r < 0 && tr[i][4]) r = i;
        end
        checks++;
        if (f < 0 || r - f != IFG + 1) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d expected %0d", r - f, IFG + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a[$];
        logic [7:0] b[$];
        rand_frame(a, 6);
        rand_frame(b, 3);
        ex.delete();
        model(a, 1'b1);
        while (ex.size() > 42) void'(ex.pop_back());
        model(b, 1'b1);
        push_frame(a, 1'b1);
        nq.delete();
        foreach (b[i]) nq.push_back({i == b.size() - 1, b[i]});
        run(ex.size(), 41);
        foreach (ex[i]) begin
            checks++;
            if (tr[i] !== ex[i]) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", i, tr[i], ex[i]);
            end
        end
        checks++;
        if (tr[42][4] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_en: got %b expected 0", tr[42][4]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_crc_vector();
        test_random();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
